// File: rtl/ysyx_22050078_wbu_pkg.sv
// Shared widths, result-source and load funct3 encodings, and FSM states for the write-back unit.
package ysyx_22050078_wbu_pkg;

  localparam int CPU_WIDTH_DEF = 64;
  localparam int REG_ADDRW_DEF = 5;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_CSR = 2'd3;

  localparam logic [2:0] LOAD_LB  = 3'd0;
  localparam logic [2:0] LOAD_LH  = 3'd1;
  localparam logic [2:0] LOAD_LW  = 3'd2;
  localparam logic [2:0] LOAD_LD  = 3'd3;
  localparam logic [2:0] LOAD_LBU = 3'd4;
  localparam logic [2:0] LOAD_LHU = 3'd5;
  localparam logic [2:0] LOAD_LWU = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_COMMIT   = 2'd2
  } wbu_state_t;

endpackage

// File: rtl/ysyx_22050078_load_ext.sv
// Load data extraction: shift the aligned doubleword down by the byte offset, then size and extend.
module ysyx_22050078_load_ext
  import ysyx_22050078_wbu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  load_type,
  output logic [63:0] ext
);

  logic [5:0]  sh;
  logic [63:0] raw;

  // Bytes shifted in from above bit 63 are zero, so boundary-crossing accesses read zeros there.
  assign sh  = {off, 3'b000};
  assign raw = rdata >> sh;

  always_comb begin
    ext = raw;
    case (load_type)
      LOAD_LB:  ext = {{56{raw[7]}},  raw[7:0]};
      LOAD_LH:  ext = {{48{raw[15]}}, raw[15:0]};
      LOAD_LW:  ext = {{32{raw[31]}}, raw[31:0]};
      LOAD_LBU: ext = {56'd0, raw[7:0]};
      LOAD_LHU: ext = {48'd0, raw[15:0]};
      LOAD_LWU: ext = {32'd0, raw[31:0]};
      default:  ext = raw;
    endcase
  end

endmodule

// File: rtl/ysyx_22050078_wbu.sv
// Write-back unit: accepts one retiring instruction, waits for load data when needed, then drives
// a single-cycle regfile write and commit pulse. Non-loads commit the cycle after accept.
module ysyx_22050078_wbu
  import ysyx_22050078_wbu_pkg::*;
#(
  parameter int CPU_WIDTH = CPU_WIDTH_DEF,
  parameter int REG_ADDRW = REG_ADDRW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic                 i_rd_wen,
  input  logic [REG_ADDRW-1:0] i_rd_addr,
  input  logic [1:0]           i_wb_sel,
  input  logic [CPU_WIDTH-1:0] i_alu_res,
  input  logic [CPU_WIDTH-1:0] i_csr_rdata,
  input  logic [2:0]           i_load_type,
  input  logic                 i_mem_rvalid,
  input  logic [CPU_WIDTH-1:0] i_mem_rdata,
  output logic                 o_wen,
  output logic [REG_ADDRW-1:0] o_waddr,
  output logic [CPU_WIDTH-1:0] o_wdata,
  output logic                 o_commit_valid,
  output logic [CPU_WIDTH-1:0] o_commit_pc,
  output logic                 o_stray_resp
);

  localparam logic [CPU_WIDTH-1:0] PC_STEP = CPU_WIDTH'(4);

  wbu_state_t           state;
  logic [CPU_WIDTH-1:0] pc_q;
  logic                 rd_wen_q;
  logic [REG_ADDRW-1:0] rd_addr_q;
  logic [2:0]           off_q;
  logic [2:0]           load_type_q;

  logic                 accept;
  logic                 new_wen;
  logic                 load_wen;
  logic [CPU_WIDTH-1:0] direct_res;
  logic [CPU_WIDTH-1:0] load_res;

  assign o_ready  = (state == ST_IDLE) | (state == ST_COMMIT);
  assign accept   = i_valid & o_ready;
  assign new_wen  = i_rd_wen & (i_rd_addr != '0);
  assign load_wen = rd_wen_q & (rd_addr_q != '0);

  always_comb begin
    direct_res = i_alu_res;
    case (i_wb_sel)
      WB_SEL_PC4: direct_res = i_pc + PC_STEP;
      WB_SEL_CSR: direct_res = i_csr_rdata;
      default:    direct_res = i_alu_res;
    endcase
  end

  ysyx_22050078_load_ext u_load_ext (
    .rdata     (i_mem_rdata),
    .off       (off_q),
    .load_type (load_type_q),
    .ext       (load_res)
  );

  // Outputs are set on the edge entering COMMIT so they are visible exactly during that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      pc_q           <= '0;
      rd_wen_q       <= 1'b0;
      rd_addr_q      <= '0;
      off_q          <= 3'd0;
      load_type_q    <= 3'd0;
      o_wen          <= 1'b0;
      o_waddr        <= '0;
      o_wdata        <= '0;
      o_commit_valid <= 1'b0;
      o_commit_pc    <= '0;
      o_stray_resp   <= 1'b0;
    end else begin
      o_wen          <= 1'b0;
      o_commit_valid <= 1'b0;
      o_stray_resp   <= i_mem_rvalid & (state != ST_WAIT_MEM);
      case (state)
        ST_WAIT_MEM: begin
          if (i_mem_rvalid) begin
            state          <= ST_COMMIT;
            o_wen          <= load_wen;
            o_commit_valid <= 1'b1;
            o_commit_pc    <= pc_q;
            if (load_wen) begin
              o_waddr <= rd_addr_q;
              o_wdata <= load_res;
            end
          end
        end
        default: begin
          if (accept) begin
            pc_q        <= i_pc;
            rd_wen_q    <= i_rd_wen;
            rd_addr_q   <= i_rd_addr;
            off_q       <= i_alu_res[2:0];
            load_type_q <= i_load_type;
            if (i_wb_sel == WB_SEL_MEM) begin
              state <= ST_WAIT_MEM;
            end else begin
              state          <= ST_COMMIT;
              o_wen          <= new_wen;
              o_commit_valid <= 1'b1;
              o_commit_pc    <= i_pc;
              if (new_wen) begin
                o_waddr <= i_rd_addr;
                o_wdata <= direct_res;
              end
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050078_wbu.sv
// Self-checking bench for the write-back unit with a behavioural load/result model.
module tb_ysyx_22050078_wbu;
  import ysyx_22050078_wbu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_pc;
  logic        i_rd_wen;
  logic [4:0]  i_rd_addr;
  logic [1:0]  i_wb_sel;
  logic [63:0] i_alu_res;
  logic [63:0] i_csr_rdata;
  logic [2:0]  i_load_type;
  logic        i_mem_rvalid;
  logic [63:0] i_mem_rdata;
  logic        o_wen;
  logic [4:0]  o_waddr;
  logic [63:0] o_wdata;
  logic        o_commit_valid;
  logic [63:0] o_commit_pc;
  logic        o_stray_resp;

  int checks = 0;
  int errors = 0;
  logic [4:0]  exp_waddr;
  logic [63:0] exp_wdata;

  always #5 clk = ~clk;

  ysyx_22050078_wbu dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc),
    .i_rd_wen(i_rd_wen), .i_rd_addr(i_rd_addr), .i_wb_sel(i_wb_sel), .i_alu_res(i_alu_res),
    .i_csr_rdata(i_csr_rdata), .i_load_type(i_load_type), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata), .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_commit_valid(o_commit_valid), .o_commit_pc(o_commit_pc), .o_stray_resp(o_stray_resp)
  );

  // Reference: pick 1/2/4/8 bytes starting at byte 'off', extend signed for funct3 0..2.
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int off, input int lt);
    logic [63:0] raw, mask, val;
    int nbytes;
    raw = rdata >> (8 * off);
    nbytes = 1 << (lt % 4);
    if (nbytes == 8) return raw;
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    val = raw & mask;
    if (lt < 3 && raw[8 * nbytes - 1]) val = val | ~mask;
    return val;
  endfunction

  function automatic logic [63:0] ref_direct(input logic [1:0] sel, input logic [63:0] pc,
                                             input logic [63:0] alu, input logic [63:0] csr);
    if (sel == WB_SEL_PC4) return pc + 64'd4;
    if (sel == WB_SEL_CSR) return csr;
    return alu;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input logic v, input logic [63:0] pc, input logic w, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] csr,
                       input logic [2:0] lt);
    i_valid = v; i_pc = pc; i_rd_wen = w; i_rd_addr = rd; i_wb_sel = sel;
    i_alu_res = alu; i_csr_rdata = csr; i_load_type = lt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 64'd0, 1'b0, 5'd0, WB_SEL_ALU, 64'd0, 64'd0, 3'd0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'd0;
    tick(); tick();
    i_mem_rvalid = 1'b0;
    checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", o_wen); end
    checks++; if (o_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", o_waddr); end
    checks++; if (o_wdata !== 64'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", o_wdata); end
    checks++; if (o_commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit got %b want 0", o_commit_valid); end
    checks++; if (o_commit_pc !== 64'd0) begin errors++; $display("FAIL reset_pc got %h want 0", o_commit_pc); end
    checks++; if (o_stray_resp !== 1'b0) begin errors++; $display("FAIL reset_stray got %b want 0", o_stray_resp); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
    rst = 1'b0;
    exp_waddr = 5'd0; exp_wdata = 64'd0;
    tick();
  endtask

  task automatic test_alu();
    logic [63:0] pc;
    pc = rand64();
    drive(1'b1, pc, 1'b1, 5'd5, WB_SEL_ALU, 64'h1234, rand64(), 3'd0);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %b want 1", o_ready); end
    tick();
    drive(1'b0, 64'd0, 1'b0, 5'd0, WB_SEL_ALU, 64'd0, 64'd0, 3'd0);
    exp_waddr = 5'd5; exp_wdata = 64'h1234;
    checks++; if (o_wen !== 1'b1) begin errors++; $display("FAIL alu_wen got %b want 1", o_wen); end
    checks++; if (o_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got %0d want 5", o_waddr); end
    checks++; if (o_wdata !== 64'h1234) begin errors++; $display("FAIL alu_wdata got %h want 1234", o_wdata); end
    checks++; if (o_commit_valid !== 1'b1) begin errors++; $display("FAIL alu_commit got %b want 1", o_commit_valid); end
    checks++; if (o_commit_pc !== pc) begin errors++; $display("FAIL alu_pc got %h want %h", o_commit_pc, pc); end
    tick();
    checks++; if (o_wen !== 1'b0 || o_commit_valid !== 1'b0) begin errors++; $display("FAIL alu_oneshot got wen=%b commit=%b want 0 0", o_wen, o_commit_valid); end
    checks++; if (o_ready !== 1'b1 || o_waddr !== exp_waddr) begin errors++; $display("FAIL alu_idle got ready=%b waddr=%0d want 1 %0d", o_ready, o_waddr, exp_waddr); end
  endtask

  task automatic test_load(input string name, input logic [2:0] lt, input logic [63:0] rdata,
                           input int off, input int delay, input logic [63:0] want);
    logic [63:0] pc;
    logic [4:0]  rd;
    pc = rand64();
    rd = 5'($urandom_range(1, 31));
    drive(1'b1, pc, 1'b1, rd, WB_SEL_MEM, {rand64() & ~64'd7} | 64'(off), rand64(), lt);
    tick();
    drive(1'b0, 64'd0, 1'b0, 5'd0, WB_SEL_ALU, 64'd0, 64'd0, 3'd0);
    for (int c = 1; c < delay; c++) begin
      checks++; if (o_ready !== 1'b0 || o_commit_valid !== 1'b0) begin errors++; $display("FAIL %s_wait got ready=%b commit=%b want 0 0", name, o_ready, o_commit_valid); end
      tick();
    end
    i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL %s_ready got %b want 0", name, o_ready); end
    tick();
    i_mem_rvalid = 1'b0; i_mem_rdata = rand64();
    exp_waddr = rd; exp_wdata = want;
    checks++; if (o_wen !== 1'b1 || o_waddr !== rd) begin errors++; $display("FAIL %s_wen got wen=%b waddr=%0d want 1 %0d", name, o_wen, o_waddr, rd); end
    checks++; if (o_wdata !== want) begin errors++; $display("FAIL %s_wdata got %h want %h", name, o_wdata, want); end
    checks++; if (o_commit_valid !== 1'b1 || o_commit_pc !== pc || o_stray_resp !== 1'b0) begin errors++; $display("FAIL %s_commit got v=%b pc=%h stray=%b want 1 %h 0", name, o_commit_valid, o_commit_pc, o_stray_resp, pc); end
    tick();
    checks++; if (o_commit_valid !== 1'b0 || o_wdata !== want) begin errors++; $display("FAIL %s_after got commit=%b wdata=%h want 0 %h", name, o_commit_valid, o_wdata, want); end
  endtask

  task automatic test_x0();
    logic [63:0] pc;
    pc = rand64();
    drive(1'b1, pc, 1'b1, 5'd0, WB_SEL_ALU, rand64(), rand64(), 3'd0);
    tick();
    drive(1'b0, 64'd0, 1'b0, 5'd0, WB_SEL_ALU, 64'd0, 64'd0, 3'd0);
    checks++; if (o_commit_valid !== 1'b1 || o_commit_pc !== pc) begin errors++; $display("FAIL x0_commit got v=%b pc=%h want 1 %h", o_commit_valid, o_commit_pc, pc); end
    checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL x0_wen got %b want 0", o_wen); end
    checks++; if (o_waddr !== exp_waddr || o_wdata !== exp_wdata) begin errors++; $display("FAIL x0_hold got %0d %h want %0d %h", o_waddr, o_wdata, exp_waddr, exp_wdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] base;
    base = 64'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, base + 64'(4 * i), 1'b1, 5'(i + 1), WB_SEL_PC4, rand64(), rand64(), 3'd0);
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, o_ready); end
      tick();
      exp_waddr = 5'(i + 1); exp_wdata = base + 64'(4 * i + 4);
      checks++; if (o_commit_valid !== 1'b1 || o_wen !== 1'b1 || o_commit_pc !== base + 64'(4 * i)) begin errors++; $display("FAIL b2b_commit[%0d] got v=%b wen=%b pc=%h", i, o_commit_valid, o_wen, o_commit_pc); end
      checks++; if (o_wdata !== exp_wdata || o_waddr !== exp_waddr) begin errors++; $display("FAIL b2b_wdata[%0d] got %h want %h", i, o_wdata, exp_wdata); end
    end
    drive(1'b0, 64'd0, 1'b0, 5'd0, WB_SEL_ALU, 64'd0, 64'd0, 3'd0);
    tick();
    checks++; if (o_commit_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", o_commit_valid); end
  endtask

  task automatic test_stray_idle();
    i_mem_rvalid = 1'b1; i_mem_rdata = rand64();
    tick();
    i_mem_rvalid = 1'b0;
    checks++; if (o_stray_resp !== 1'b1) begin errors++; $display("FAIL stray_idle got %b want 1", o_stray_resp); end
    checks++; if (o_wen !== 1'b0 || o_commit_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL stray_idle_state got wen=%b commit=%b ready=%b want 0 0 1", o_wen, o_commit_valid, o_ready); end
    tick();
    checks++; if (o_stray_resp !== 1'b0) begin errors++; $display("FAIL stray_pulse got %b want 0", o_stray_resp); end
  endtask

  task automatic test_stray_commit();
    logic [63:0] pc, d2;
    drive(1'b1, rand64(), 1'b1, 5'd7, WB_SEL_ALU, 64'h77, 64'd0, 3'd0);
    tick();
    exp_waddr = 5'd7; exp_wdata = 64'h77;
    pc = rand64(); d2 = rand64();
    drive(1'b1, pc, 1'b1, 5'd9, WB_SEL_MEM, 64'h1000, 64'd0, LOAD_LD);
    i_mem_rvalid = 1'b1; i_mem_rdata = rand64();
    tick();
    drive(1'b0, 64'd0, 1'b0, 5'd0, WB_SEL_ALU, 64'd0, 64'd0, 3'd0);
    checks++; if (o_stray_resp !== 1'b1 || o_ready !== 1'b0 || o_commit_valid !== 1'b0) begin errors++; $display("FAIL stray_commit got stray=%b ready=%b commit=%b want 1 0 0", o_stray_resp, o_ready, o_commit_valid); end
    i_mem_rdata = d2;
    tick();
    i_mem_rvalid = 1'b0;
    exp_waddr = 5'd9; exp_wdata = d2;
    checks++; if (o_commit_valid !== 1'b1 || o_wdata !== d2 || o_commit_pc !== pc || o_stray_resp !== 1'b0) begin errors++; $display("FAIL stray_commit_load got v=%b wdata=%h stray=%b want 1 %h 0", o_commit_valid, o_wdata, o_stray_resp, d2); end
    tick();
  endtask

  task automatic test_random_mixed();
    logic v, w;
    logic [1:0] sel;
    logic [4:0] rd;
    logic [63:0] pc, alu, csr, want;
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0: sel = WB_SEL_ALU;
        1: sel = WB_SEL_PC4;
        default: sel = WB_SEL_CSR;
      endcase
      rd = 5'($urandom_range(0, 31)); w = 1'($urandom_range(0, 1));
      pc = rand64(); alu = rand64(); csr = rand64();
      if (i == 0) pc = 64'hFFFF_FFFF_FFFF_FFFE;
      drive(v, pc, w, rd, sel, alu, csr, 3'd0);
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mix_ready[%0d] got %b want 1", i, o_ready); end
      tick();
      if (v && w && rd != 5'd0) begin
        exp_waddr = rd; exp_wdata = ref_direct(sel, pc, alu, csr);
      end
      want = exp_wdata;
      checks++; if (o_commit_valid !== v || o_wen !== (v && w && rd != 5'd0)) begin errors++; $display("FAIL mix_ctl[%0d] got v=%b wen=%b", i, o_commit_valid, o_wen); end
      checks++; if (o_waddr !== exp_waddr || o_wdata !== want) begin errors++; $display("FAIL mix_data[%0d] got %0d %h want %0d %h", i, o_waddr, o_wdata, exp_waddr, want); end
      if (v) begin
        checks++; if (o_commit_pc !== pc) begin errors++; $display("FAIL mix_pc[%0d] got %h want %h", i, o_commit_pc, pc); end
      end
    end
    drive(1'b0, 64'd0, 1'b0, 5'd0, WB_SEL_ALU, 64'd0, 64'd0, 3'd0);
    tick();
  endtask

  task automatic test_reset_wait();
    drive(1'b1, rand64(), 1'b1, 5'd12, WB_SEL_MEM, 64'h2000, 64'd0, LOAD_LW);
    tick();
    drive(1'b0, 64'd0, 1'b0, 5'd0, WB_SEL_ALU, 64'd0, 64'd0, 3'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (o_wen !== 1'b0 || o_commit_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL rstwait_state got wen=%b commit=%b ready=%b want 0 0 1", o_wen, o_commit_valid, o_ready); end
    i_mem_rvalid = 1'b1; i_mem_rdata = rand64();
    tick();
    i_mem_rvalid = 1'b0;
    checks++; if (o_stray_resp !== 1'b1) begin errors++; $display("FAIL rstwait_stray got %b want 1", o_stray_resp); end
    checks++; if (o_wen !== 1'b0 || o_commit_valid !== 1'b0 || o_ready !== 1'b1 || o_waddr !== 5'd0) begin errors++; $display("FAIL rstwait_resp got wen=%b commit=%b ready=%b waddr=%0d want 0 0 1 0", o_wen, o_commit_valid, o_ready, o_waddr); end
    tick();
  endtask

  initial begin
    logic [63:0] rd64;
    int off, lt, dly;
    test_reset();
    test_alu();
    test_load("lb", LOAD_LB, 64'h0000_0000_8000_0000, 3, 4, 64'hFFFF_FFFF_FFFF_FF80);
    test_load("lbu", LOAD_LBU, 64'h0000_0000_8000_0000, 3, 4, 64'h0000_0000_0000_0080);
    test_load("lh_fast", LOAD_LH, 64'h0000_0000_0000_8001, 0, 1, 64'hFFFF_FFFF_FFFF_8001);
    test_x0();
    test_back_to_back();
    test_stray_idle();
    test_stray_commit();
    for (int i = 0; i < 24; i++) begin
      rd64 = rand64();
      off = $urandom_range(0, 7);
      lt = $urandom_range(0, 7);
      dly = $urandom_range(1, 3);
      test_load("rand_load", 3'(lt), rd64, off, dly, ref_load(rd64, off, lt));
    end
    test_random_mixed();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
